reaction_measure: RTL
=====================

// Module: reaction_measure
// PURPOSE
// - Reaction-test sequencer feeding the BCD digit/seven-segment display path; drives the stimulus LED.
// - Start press -> pseudo-random delay -> stimulus LED on -> count ms until react press.
// - Outputs elapsed ms as 4 BCD digits (live while counting, held after) plus status flags.
// PARAMETERS
// - MS_DIV        100000  clk cycles per 1 ms tick (100 MHz clk)
// - MIN_DELAY_MS  1000    minimum stimulus delay; delay = MIN_DELAY_MS + lfsr[10:0] (1000..3047 ms)
// PORTS
// - clk           in   1   system clock
// - ck_rst        in   1   synchronous reset, active-high
// - start_btn     in   1   async level, start request
// - react_btn     in   1   async level, reaction press
// - stim_led      out  1   stimulus light, high while waiting for reaction
// - digits_bcd    out  16  {thousands,hundreds,tens,ones} BCD ms count
// - result_valid  out  1   high while a completed result is held
// - busy          out  1   high in WAIT_DELAY or ARMED
// - false_start   out  1   react pressed before stimulus
// - timeout       out  1   count saturated at 9999 without react
// - best_bcd      out  16  best (minimum) valid result, BCD
// BEHAVIOUR
// - One clock, one sync active-high reset; no other clocks or enables.
// - Reset values: stim_led=0, digits_bcd=16'h0000, result_valid=0, busy=0, false_start=0,
//   timeout=0, best_bcd=16'h9999, state=IDLE, lfsr=16'hACE1, prescaler=0.
// - Each button: 2-flop sync + previous-value reg; press pulse = sync & ~prev.
//   Pin rising before edge N -> state register acts at edge N+2. Held buttons give one pulse.
// - LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle, never all-zero.
// - Prescaler: counts 0..MS_DIV-1, tick on wrap; cleared on every state entry,
//   so first tick occurs exactly MS_DIV cycles after entry.
// - States / transitions:
//   IDLE: start -> WAIT_DELAY (latch delay from lfsr, digits=0). react ignored.
//   WAIT_DELAY: busy=1; decrement delay per tick; reaches 0 -> ARMED (stim_led=1).
//     react -> FALSE_START. start ignored.
//   ARMED: busy=1, stim_led=1; digits_bcd BCD-increments per tick (ones carry at 9, etc).
//     react -> DONE (result_valid=1). Tick while digits=9999 -> DONE, timeout=1, digits stay 9999.
//     start ignored.
//   DONE: stim_led=0, busy=0, digits held. start -> WAIT_DELAY, clears digits/flags.
//   FALSE_START: false_start=1, digits=16'h0000, stim_led=0. start -> WAIT_DELAY, clears flag.
// - Simultaneous react+tick in ARMED: react wins, tick not counted.
// - Simultaneous start+react in IDLE/DONE/FALSE_START: start wins, react dropped.
// - Reset mid-operation: all outputs return to reset values at that edge; best_bcd also cleared.
// - Digits never hold a non-BCD nibble.
// CONFIGURATION
// - BEST_TIME_EN defined: on entry to DONE with timeout=0, if digits_bcd < best_bcd
//   (BCD compare), best_bcd <= digits_bcd in same edge. Timeouts/false starts never update it.
// - BEST_TIME_EN undefined: comparator/register omitted; best_bcd tied to 16'h9999.
// TESTING (bench uses MS_DIV=10, MIN_DELAY_MS=2)
// - Reset 5 cycles -> all outputs at reset values, state IDLE; react pulse in IDLE -> no change.
// - Start; react 37*MS_DIV+5 cycles after stim_led rise -> digits_bcd=16'h0037,
//   result_valid=1, stim_led=0, busy=0.
// - Start; react before stim_led rises -> false_start=1, digits=16'h0000, stim_led never rises;
//   next start clears false_start and re-enters WAIT_DELAY.
// - Start, no react -> after 10000 ticks in ARMED: digits=16'h9999, timeout=1, result_valid=1.
// - ck_rst asserted mid-ARMED with digits=16'h0123 -> next edge all outputs at reset values.
// - BEST_TIME_EN: runs 0052, 0037, 0048, then timeout -> best_bcd=16'h0037;
//   without macro best_bcd=16'h9999 throughout.

Source files
------------

// File: rtl/reaction_measure_if.sv
// Button inputs and display/status outputs of the reaction-test sequencer.
interface reaction_measure_if;
   logic        start_btn;
   logic        react_btn;
   logic        stim_led;
   logic [15:0] digits_bcd;
   logic        result_valid;
   logic        busy;
   logic        false_start;
   logic        timeout;
   logic [15:0] best_bcd;

   modport master (
      output start_btn, react_btn,
      input  stim_led, digits_bcd, result_valid, busy, false_start, timeout, best_bcd
   );

   modport slave (
      input  start_btn, react_btn,
      output stim_led, digits_bcd, result_valid, busy, false_start, timeout, best_bcd
   );
endinterface

// File: rtl/reaction_measure.sv
// Reaction-test sequencer: random delay, stimulus LED, BCD millisecond count of the reaction.
// Optional best-time tracking is enabled by defining BEST_TIME_EN.
module reaction_measure #(
   parameter int unsigned MS_DIV       = 100000,
   parameter int unsigned MIN_DELAY_MS = 1000
) (
   input logic               clk,
   input logic               ck_rst,
   reaction_measure_if.slave bus
);

   localparam int unsigned PW        = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam int unsigned DW        = $clog2(MIN_DELAY_MS + 2048);
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] BCD_MAX   = 16'h9999;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DELAY,
      ARMED,
      DONE,
      FALSE_START
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [1:0]      start_sync;
   logic [1:0]      react_sync;
   logic            start_prev;
   logic            react_prev;
   logic            start_press_c;
   logic            react_press_c;
   logic [15:0]     lfsr;
   logic [PW-1:0]   presc;
   logic            tick_c;
   logic [DW-1:0]   delay_cnt;
   logic [DW-1:0]   delay_next;
   logic [15:0]     digits_q;
   logic [15:0]     digits_next;
   logic            valid_q;
   logic            valid_next;
   logic            fstart_q;
   logic            fstart_next;
   logic            timeout_q;
   logic            timeout_next;
   logic            stim_q;
   logic            busy_q;

   // Decimal increment of a four-digit BCD value; 9999 wraps, callers avoid that case.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Two-flop synchronisers plus edge detect: one press pulse per rising edge.
   always_ff @(posedge clk) begin
      if (ck_rst) begin
         start_sync <= 2'b00;
         react_sync <= 2'b00;
         start_prev <= 1'b0;
         react_prev <= 1'b0;
      end else begin
         start_sync <= {start_sync[0], bus.start_btn};
         react_sync <= {react_sync[0], bus.react_btn};
         start_prev <= start_sync[1];
         react_prev <= react_sync[1];
      end
   end

   assign start_press_c = start_sync[1] & ~start_prev;
   assign react_press_c = react_sync[1] & ~react_prev;

   // Fibonacci LFSR, taps 16,14,13,11, free running.
   always_ff @(posedge clk) begin
      if (ck_rst) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end
   end

   // Millisecond prescaler, restarted on each state change.
   always_ff @(posedge clk) begin
      if (ck_rst) begin
         presc <= '0;
      end else if (state_next != state || tick_c) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   assign tick_c = (presc == PW'(MS_DIV - 1));

   always_ff @(posedge clk) begin
      if (ck_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and next datapath values; react beats tick, start beats react.
   always_comb begin
      state_next   = state;
      delay_next   = delay_cnt;
      digits_next  = digits_q;
      valid_next   = valid_q;
      fstart_next  = fstart_q;
      timeout_next = timeout_q;
      case (state)
         IDLE, DONE, FALSE_START: begin
            if (start_press_c) begin
               state_next   = WAIT_DELAY;
               delay_next   = DW'(MIN_DELAY_MS) + DW'(lfsr[10:0]);
               digits_next  = 16'h0000;
               valid_next   = 1'b0;
               fstart_next  = 1'b0;
               timeout_next = 1'b0;
            end
         end
         WAIT_DELAY: begin
            if (react_press_c) begin
               state_next  = FALSE_START;
               fstart_next = 1'b1;
               digits_next = 16'h0000;
            end else if (tick_c) begin
               if (delay_cnt <= DW'(1)) begin
                  state_next = ARMED;
               end else begin
                  delay_next = delay_cnt - DW'(1);
               end
            end
         end
         ARMED: begin
            if (react_press_c) begin
               state_next = DONE;
               valid_next = 1'b1;
            end else if (tick_c) begin
               if (digits_q == BCD_MAX) begin
                  state_next   = DONE;
                  valid_next   = 1'b1;
                  timeout_next = 1'b1;
               end else begin
                  digits_next = bcd_inc(digits_q);
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Registered datapath and outputs; LED/busy follow the state being entered.
   always_ff @(posedge clk) begin
      if (ck_rst) begin
         delay_cnt <= '0;
         digits_q  <= 16'h0000;
         valid_q   <= 1'b0;
         fstart_q  <= 1'b0;
         timeout_q <= 1'b0;
         stim_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         delay_cnt <= delay_next;
         digits_q  <= digits_next;
         valid_q   <= valid_next;
         fstart_q  <= fstart_next;
         timeout_q <= timeout_next;
         stim_q    <= (state_next == ARMED);
         busy_q    <= (state_next == WAIT_DELAY) || (state_next == ARMED);
      end
   end

   assign bus.stim_led     = stim_q;
   assign bus.digits_bcd   = digits_q;
   assign bus.result_valid = valid_q;
   assign bus.busy         = busy_q;
   assign bus.false_start  = fstart_q;
   assign bus.timeout      = timeout_q;

`ifdef BEST_TIME_EN
   logic [15:0] best_q;
   logic        best_upd_c;

   // Packed BCD digits order the same as their decimal values, so a plain compare suffices.
   assign best_upd_c = (state != DONE) && (state_next == DONE) && !timeout_next
                       && (digits_next < best_q);

   always_ff @(posedge clk) begin
      if (ck_rst) begin
         best_q <= BCD_MAX;
      end else if (best_upd_c) begin
         best_q <= digits_next;
      end
   end

   assign bus.best_bcd = best_q;
`else
   assign bus.best_bcd = BCD_MAX;
`endif

endmodule
